// File: rtl/player_shot_controller.sv
// player_shot_controller: launches, flies and retires the player's single
// laser shot, then holds off the next launch for a frame-counted cooldown.
module player_shot_controller #(
  parameter int SHOT_SPEED      = 8,
  parameter int PLAYER_WIDTH    = 64,
  parameter int SHOT_WIDTH      = 4,
  parameter int SHOT_HEIGHT     = 16,
  parameter int TOP_LIMIT       = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enter,
  input  logic               playGame,
  input  logic               shotHit,
  input  logic signed [10:0] playerTopLeftX,
  input  logic signed [10:0] playerTopLeftY,
  output logic signed [10:0] shotTopLeftX,
  output logic signed [10:0] shotTopLeftY,
  output logic               shotActive,
  output logic               shotFired,
  output logic [7:0]         shotCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  // Shot is centred horizontally on the player and sits just above it.
  localparam logic signed [10:0] X_OFFSET   = 11'(PLAYER_WIDTH / 2 - SHOT_WIDTH / 2);
  localparam logic signed [10:0] Y_OFFSET   = 11'(SHOT_HEIGHT);
  // Flight arithmetic is one bit wider so a shot near the top cannot wrap.
  localparam logic signed [11:0] SPEED_12   = 12'(SHOT_SPEED);
  localparam logic signed [11:0] LIMIT_12   = 12'(TOP_LIMIT);
  localparam logic [15:0]        COOL_LOAD  = 16'(COOLDOWN_FRAMES);

  state_t             state_r;
  logic               enterD_r;
  logic [15:0]        cooldownCnt_r;

  logic               press_s;
  logic signed [10:0] launchX_s;
  logic signed [10:0] launchY_s;
  logic signed [11:0] newY_s;
  logic               topReached_s;

  // Launch coordinates, next flight position and fire-key edge detection.
  always_comb begin
    press_s      = enter & ~enterD_r;
    launchX_s    = playerTopLeftX + X_OFFSET;
    launchY_s    = playerTopLeftY - Y_OFFSET;
    newY_s       = {shotTopLeftY[10], shotTopLeftY} - SPEED_12;
    topReached_s = (newY_s < LIMIT_12);
  end

  // Shot state machine with registered coordinates, flags and launch count.
  always_ff @(posedge clk) begin
    if (resetN || !playGame) begin
      state_r       <= IDLE;
      enterD_r      <= 1'b0;
      cooldownCnt_r <= 16'd0;
      shotTopLeftX  <= 11'sd0;
      shotTopLeftY  <= 11'sd0;
      shotActive    <= 1'b0;
      shotFired     <= 1'b0;
      shotCount     <= 8'd0;
    end else begin
      enterD_r  <= enter;
      shotFired <= 1'b0;
      case (state_r)
        IDLE: begin
          if (press_s) begin
            shotTopLeftX <= launchX_s;
            shotTopLeftY <= launchY_s;
            shotFired    <= 1'b1;
            shotActive   <= 1'b1;
            shotCount    <= shotCount + 8'd1;
            state_r      <= FLYING;
          end
        end
        FLYING: begin
          if (shotHit) begin
            // A hit wins over a same-cycle frame tick: Y stays where it was.
            cooldownCnt_r <= COOL_LOAD;
            shotActive    <= 1'b0;
            state_r       <= COOLDOWN;
          end else if (startOfFrame) begin
            if (topReached_s) begin
              cooldownCnt_r <= COOL_LOAD;
              shotActive    <= 1'b0;
              state_r       <= COOLDOWN;
            end else begin
              shotTopLeftY <= newY_s[10:0];
            end
          end
        end
        COOLDOWN: begin
          if (cooldownCnt_r == 16'd0) begin
            state_r <= IDLE;
          end else if (startOfFrame) begin
            cooldownCnt_r <= cooldownCnt_r - 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          shotActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_shot_controller.sv
// tb_player_shot_controller: table-driven vectors plus hand-written
// multi-cycle sequences, checked through an expected-value queue.
module tb_player_shot_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetN, playGame;
  logic               enter, startOfFrame, shotHit;
  logic               enter0, startOfFrame0, shotHit0;
  logic signed [10:0] px, py;

  logic signed [10:0] sx, sy, sx0, sy0;
  logic               act, fired, act0, fired0;
  logic [7:0]         cnt, cnt0;

  int checks = 0;
  int errors = 0;

  player_shot_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enter(enter),
    .playGame(playGame), .shotHit(shotHit),
    .playerTopLeftX(px), .playerTopLeftY(py),
    .shotTopLeftX(sx), .shotTopLeftY(sy),
    .shotActive(act), .shotFired(fired), .shotCount(cnt)
  );

  player_shot_controller #(.COOLDOWN_FRAMES(0)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame0), .enter(enter0),
    .playGame(playGame), .shotHit(shotHit0),
    .playerTopLeftX(px), .playerTopLeftY(py),
    .shotTopLeftX(sx0), .shotTopLeftY(sy0),
    .shotActive(act0), .shotFired(fired0), .shotCount(cnt0)
  );

  typedef struct {
    string              name;
    logic [4:0]         ctl;   // {resetN, playGame, enter, startOfFrame, shotHit}
    logic signed [10:0] px, py;
    logic signed [10:0] ex, ey;
    logic               ea, ef;
    logic [7:0]         ec;
  } vec_t;

  typedef struct {
    string              name;
    logic               sel;
    logic signed [10:0] x, y;
    logic               a, f;
    logic [7:0]         c;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[17];

  function automatic vec_t mk(string n, logic [4:0] ctl, int vx, int vy,
                              int ex, int ey, logic [1:0] af, int ec);
    vec_t v;
    v.name = n; v.ctl = ctl;
    v.px = 11'(vx); v.py = 11'(vy);
    v.ex = 11'(ex); v.ey = 11'(ey);
    v.ea = af[1]; v.ef = af[0]; v.ec = 8'(ec);
    return v;
  endfunction

  task automatic compare_head();
    exp_t e;
    logic signed [10:0] ax, ay;
    logic aa, af;
    logic [7:0] ac;
    e = expQ.pop_front();
    if (e.sel) begin
      ax = sx0; ay = sy0; aa = act0; af = fired0; ac = cnt0;
    end else begin
      ax = sx; ay = sy; aa = act; af = fired; ac = cnt;
    end
    checks++;
    if (ax !== e.x || ay !== e.y || aa !== e.a || af !== e.f || ac !== e.c) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d act=%0b fired=%0b cnt=%0d, want x=%0d y=%0d act=%0b fired=%0b cnt=%0d",
               e.name, ax, ay, aa, af, ac, e.x, e.y, e.a, e.f, e.c);
    end
  endtask

  task automatic expect_next(string n, logic sel, int x, int y, logic a, logic f, int c);
    exp_t e;
    e.name = n; e.sel = sel; e.x = 11'(x); e.y = 11'(y); e.a = a; e.f = f; e.c = 8'(c);
    expQ.push_back(e);
    @(posedge clk); #1;
    compare_head();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    resetN = 1'b1; playGame = 1'b1;
    enter = 1'b0; startOfFrame = 1'b0; shotHit = 1'b0;
    enter0 = 1'b0; startOfFrame0 = 1'b0; shotHit0 = 1'b0;
    px = 11'sd240; py = 11'sd420;

    vecs[0]  = mk("reset",          5'b11000, 240, 420,   0,   0, 2'b00, 0);
    vecs[1]  = mk("idle",           5'b01000, 240, 420,   0,   0, 2'b00, 0);
    vecs[2]  = mk("launch",         5'b01100, 240, 420, 270, 404, 2'b11, 1);
    vecs[3]  = mk("fired_one_wide", 5'b01100, 240, 420, 270, 404, 2'b10, 1);
    vecs[4]  = mk("move1",          5'b01110, 240, 420, 270, 396, 2'b10, 1);
    vecs[5]  = mk("x_const",        5'b01000, 100, 420, 270, 396, 2'b10, 1);
    vecs[6]  = mk("hit_priority",   5'b01011, 240, 420, 270, 396, 2'b00, 1);
    vecs[7]  = mk("cool_press",     5'b01100, 240, 420, 270, 396, 2'b00, 1);
    vecs[8]  = mk("pg_clear_cool",  5'b00100, 240, 420,   0,   0, 2'b00, 0);
    vecs[9]  = mk("after_clear",    5'b01000, 240, 420,   0,   0, 2'b00, 0);
    vecs[10] = mk("launch2",        5'b01100,   0, 100,  30,  84, 2'b11, 1);
    vecs[11] = mk("move2",          5'b01010,   0, 100,  30,  76, 2'b10, 1);
    vecs[12] = mk("rst_flight",     5'b11000,   0, 100,   0,   0, 2'b00, 0);
    vecs[13] = mk("launch_neg",     5'b01100, -40,  10, -10,  -6, 2'b11, 1);
    vecs[14] = mk("top_immediate",  5'b01010, -40,  10, -10,  -6, 2'b00, 1);
    vecs[15] = mk("cool_hold",      5'b01000, -40,  10, -10,  -6, 2'b00, 1);
    vecs[16] = mk("rst_cool",       5'b11000, -40,  10,   0,   0, 2'b00, 0);

    tick(); tick();

    for (int i = 0; i < 17; i++) begin
      {resetN, playGame, enter, startOfFrame, shotHit} = vecs[i].ctl;
      px = vecs[i].px; py = vecs[i].py;
      expect_next(vecs[i].name, 1'b0, vecs[i].ex, vecs[i].ey, vecs[i].ea, vecs[i].ef, vecs[i].ec);
    end

    resetN = 1'b0; playGame = 1'b1; enter = 1'b0; startOfFrame = 1'b0; shotHit = 1'b0;
    px = 11'sd240; py = 11'sd420;
    tick();

    // Flight to the top, then the cooldown boundary.
    enter = 1'b1;
    expect_next("a_launch", 1'b0, 270, 404, 1'b1, 1'b1, 1);
    enter = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      startOfFrame = 1'b1;
      expect_next("a_fly", 1'b0, 270, 404 - 8 * k, 1'b1, 1'b0, 1);
      startOfFrame = 1'b0;
      tick();
    end
    startOfFrame = 1'b1;
    expect_next("a_top", 1'b0, 270, 20, 1'b0, 1'b0, 1);
    startOfFrame = 1'b0;
    tick();
    for (int f = 1; f <= 7; f++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; enter = 1'b1;
    expect_next("a_press_cnt0", 1'b0, 270, 20, 1'b0, 1'b0, 1);
    expect_next("a_held", 1'b0, 270, 20, 1'b0, 1'b0, 1);
    enter = 1'b0; tick();
    enter = 1'b1;
    expect_next("a_refire", 1'b0, 270, 404, 1'b1, 1'b1, 2);
    enter = 1'b0;

    // Held fire key over 100 frames launches once only.
    resetN = 1'b1; tick(); resetN = 1'b0;
    enter = 1'b1;
    expect_next("b_launch", 1'b0, 270, 404, 1'b1, 1'b1, 1);
    for (int f = 1; f <= 100; f++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    expect_next("b_no_autofire", 1'b0, 270, 20, 1'b0, 1'b0, 1);
    enter = 1'b0; tick();
    enter = 1'b1;
    expect_next("b_refire", 1'b0, 270, 404, 1'b1, 1'b1, 2);
    enter = 1'b0;
    playGame = 1'b0;
    expect_next("b_pg_flight", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    playGame = 1'b1;
    tick();

    // Launch counter wraps from 255 to 0.
    for (int i = 1; i <= 256; i++) begin
      enter = 1'b1;
      if (i >= 254) expect_next("d_launch", 1'b0, 270, 404, 1'b1, 1'b1, i % 256);
      else tick();
      enter = 1'b0; shotHit = 1'b1; tick();
      shotHit = 1'b0;
      for (int f = 0; f < 8; f++) begin
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0; tick();
      end
      tick();
    end

    // Zero-length cooldown: IDLE two cycles after the hit.
    resetN = 1'b1; tick(); resetN = 1'b0;
    enter0 = 1'b1;
    expect_next("e_launch", 1'b1, 270, 404, 1'b1, 1'b1, 1);
    enter0 = 1'b0; shotHit0 = 1'b1;
    expect_next("e_hit", 1'b1, 270, 404, 1'b0, 1'b0, 1);
    shotHit0 = 1'b0; enter0 = 1'b1;
    expect_next("e_press_cool", 1'b1, 270, 404, 1'b0, 1'b0, 1);
    enter0 = 1'b0; tick();
    enter0 = 1'b1;
    expect_next("e_fire2", 1'b1, 270, 404, 1'b1, 1'b1, 2);
    enter0 = 1'b0; shotHit0 = 1'b1; tick();
    shotHit0 = 1'b0; tick();
    enter0 = 1'b1;
    expect_next("e_fire3", 1'b1, 270, 404, 1'b1, 1'b1, 3);
    enter0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
